// File: rtl/or1k_branch_predictor_ctrl.sv
// or1k_branch_predictor_ctrl
// Update-side controller for the gshare pattern-history table.
// After reset it walks every entry and writes weakly-taken (2'b10). It then
// drains a small FIFO of resolved-branch updates, one read-modify-write per
// two cycles. The optional flush feature is compiled in with the macro
// OR1K_BP_FLUSH_EN. Without it, flush_i is ignored.
//
// Handshake: an update transfers on a rising clk edge where upd_valid_i and
// upd_ready_o are both high. upd_ready_o does not depend on upd_valid_i.
// During the init walk updates are always accepted and then dropped.
module or1k_branch_predictor_ctrl #(
    parameter int GSHARE_BITS_NUM = 10,
    parameter int UPD_FIFO_DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       upd_valid_i,
    input  logic [GSHARE_BITS_NUM-1:0] upd_idx_i,
    input  logic                       upd_taken_i,
    output logic                       upd_ready_o,
    output logic                       busy_o,
    output logic                       tbl_re_o,
    output logic [GSHARE_BITS_NUM-1:0] tbl_ridx_o,
    input  logic [1:0]                 tbl_rd_data_i,
    output logic                       tbl_we_o,
    output logic [GSHARE_BITS_NUM-1:0] tbl_widx_o,
    output logic [1:0]                 tbl_wdata_o,
    output logic [1:0]                 dbg_state
);

    localparam int FIFO_AW = $clog2(UPD_FIFO_DEPTH);
    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [GSHARE_BITS_NUM-1:0] LAST_IDX = '1;

    logic [1:0]                 state;
    logic [GSHARE_BITS_NUM-1:0] cnt;
    logic [GSHARE_BITS_NUM-1:0] lat_idx;
    logic                       lat_taken;

    // Each FIFO entry is {idx, taken}.
    logic [GSHARE_BITS_NUM:0]   fifo_mem [UPD_FIFO_DEPTH];
    logic [FIFO_AW:0]           wr_ptr;
    logic [FIFO_AW:0]           rd_ptr;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic [GSHARE_BITS_NUM:0]   head;
    logic                       push;
    logic                       pop;
    logic                       flush;

`ifdef OR1K_BP_FLUSH_EN
    assign flush = flush_i;
`else
    logic unused_flush;
    assign unused_flush = flush_i;
    assign flush        = 1'b0;
`endif

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == 2'b11) ? 2'b11 : v + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] v);
        return (v == 2'b00) ? 2'b00 : v - 2'b01;
    endfunction

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign head       = fifo_mem[rd_ptr[FIFO_AW-1:0]];

    assign busy_o      = (state == ST_INIT);
    // A full FIFO refuses a push even when it is popping in the same cycle.
    assign upd_ready_o = busy_o || !fifo_full;
    // Updates accepted during the walk, or together with a flush, are dropped.
    assign push        = upd_valid_i && upd_ready_o && !busy_o && !flush;
    assign pop         = (state == ST_IDLE) && !fifo_empty;
    assign dbg_state   = state;

    // FIFO storage: written on push only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[FIFO_AW-1:0]] <= {upd_idx_i, upd_taken_i};
        end
    end

    // FIFO pointers: flush empties the FIFO at the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Control FSM: init walk, then serial read-modify-write updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_INIT;
            cnt       <= '0;
            lat_idx   <= '0;
            lat_taken <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (flush) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_IDX) state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (flush) begin
                        state <= ST_INIT;
                        cnt   <= '0;
                    end else if (!fifo_empty) begin
                        state     <= ST_WRITE;
                        lat_idx   <= head[GSHARE_BITS_NUM:1];
                        lat_taken <= head[0];
                    end
                end
                ST_WRITE: begin
                    // The write of this cycle always completes.
                    state <= flush ? ST_INIT : ST_IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= ST_INIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Table port drive, decoded from state, walk counter and FIFO head.
    always_comb begin
        tbl_re_o    = 1'b0;
        tbl_ridx_o  = '0;
        tbl_we_o    = 1'b0;
        tbl_widx_o  = '0;
        tbl_wdata_o = 2'b00;
        case (state)
            ST_INIT: begin
                tbl_we_o    = 1'b1;
                tbl_widx_o  = cnt;
                tbl_wdata_o = 2'b10;
            end
            ST_IDLE: begin
                tbl_re_o   = !fifo_empty;
                tbl_ridx_o = head[GSHARE_BITS_NUM:1];
            end
            ST_WRITE: begin
                tbl_we_o    = 1'b1;
                tbl_widx_o  = lat_idx;
                tbl_wdata_o = lat_taken ? sat_inc(tbl_rd_data_i)
                                        : sat_dec(tbl_rd_data_i);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_or1k_branch_predictor_ctrl.sv
// Bench for or1k_branch_predictor_ctrl with GSHARE_BITS_NUM=4 and a depth-4 FIFO.
module tb_or1k_branch_predictor_ctrl;
  localparam int G     = 4;
  localparam int DEPTH = 4;
  localparam int NUM   = 1 << G;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush_i;
  logic         upd_valid_i;
  logic [G-1:0] upd_idx_i;
  logic         upd_taken_i;
  logic         upd_ready_o;
  logic         busy_o;
  logic         tbl_re_o;
  logic [G-1:0] tbl_ridx_o;
  logic [1:0]   tbl_rd_data_i;
  logic         tbl_we_o;
  logic [G-1:0] tbl_widx_o;
  logic [1:0]   tbl_wdata_o;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [G-1:0] idx;
    logic         taken;
    logic [1:0]   exp;
  } vec_t;
  vec_t vecs[9];

  // Table RAM: one synchronous read port, one write port.
  logic [1:0] ram[NUM];

  // Reference model state.
  logic [1:0]   ref_tbl[NUM];
  logic [G+1:0] exp_q[$];
  int           occ;
  int           init_exp;
  bit           prev_busy;
  int           stall_cnt;

  or1k_branch_predictor_ctrl #(.GSHARE_BITS_NUM(G), .UPD_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .upd_valid_i(upd_valid_i), .upd_idx_i(upd_idx_i), .upd_taken_i(upd_taken_i),
    .upd_ready_o(upd_ready_o), .busy_o(busy_o),
    .tbl_re_o(tbl_re_o), .tbl_ridx_o(tbl_ridx_o), .tbl_rd_data_i(tbl_rd_data_i),
    .tbl_we_o(tbl_we_o), .tbl_widx_o(tbl_widx_o), .tbl_wdata_o(tbl_wdata_o),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tbl_we_o) ram[tbl_widx_o] <= tbl_wdata_o;
    if (tbl_re_o) tbl_rd_data_i <= ram[tbl_ridx_o];
  end

  task automatic check(input bit ok, input string name, input int act, input int exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] counter_step(input logic [1:0] v, input logic taken);
    int n;
    n = int'(v) + (taken ? 1 : -1);
    if (n > 3) n = 3;
    if (n < 0) n = 0;
    return n[1:0];
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    bit flush_eff;
`ifdef OR1K_BP_FLUSH_EN
    flush_eff = flush_i;
`else
    flush_eff = 1'b0;
`endif
    if (rst) begin
      exp_q.delete();
      occ = 0;
      init_exp = 0;
      prev_busy = 1'b1;
      for (int i = 0; i < NUM; i++) ref_tbl[i] = 2'b10;
    end else begin
      if (busy_o) begin
        check(tbl_we_o == 1'b1, "init_we", tbl_we_o, 1);
        check(tbl_widx_o == init_exp[G-1:0], "init_widx", tbl_widx_o, init_exp);
        check(tbl_wdata_o == 2'b10, "init_wdata", tbl_wdata_o, 2);
        check(tbl_re_o == 1'b0, "init_re", tbl_re_o, 0);
        init_exp++;
      end else if (tbl_we_o) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "spurious_write", tbl_widx_o, -1);
        end else begin
          logic [G+1:0] e;
          e = exp_q.pop_front();
          check({tbl_widx_o, tbl_wdata_o} == e, "upd_write", {tbl_widx_o, tbl_wdata_o}, e);
        end
      end
      if (prev_busy && !busy_o)
        check(init_exp == NUM, "init_len", init_exp, NUM);
      prev_busy = busy_o;
      check(upd_ready_o == (busy_o || occ < DEPTH), "ready", upd_ready_o, busy_o || occ < DEPTH);
      if (upd_valid_i && upd_ready_o && !busy_o && !flush_eff) begin
        logic [1:0] nv;
        nv = counter_step(ref_tbl[upd_idx_i], upd_taken_i);
        ref_tbl[upd_idx_i] = nv;
        exp_q.push_back({upd_idx_i, nv});
        occ++;
      end
      if (tbl_re_o) occ--;
      if (flush_eff) begin
        exp_q.delete();
        occ = 0;
        init_exp = 0;
        for (int i = 0; i < NUM; i++) ref_tbl[i] = 2'b10;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    upd_valid_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check(busy_o == 1'b1, "rst_busy", busy_o, 1);
      check(upd_ready_o == 1'b1, "rst_ready", upd_ready_o, 1);
      check(tbl_re_o == 1'b0, "rst_re", tbl_re_o, 0);
      check(tbl_we_o == 1'b1, "rst_we", tbl_we_o, 1);
      check(tbl_widx_o == '0, "rst_widx", tbl_widx_o, 0);
      check(tbl_wdata_o == 2'b10, "rst_wdata", tbl_wdata_o, 2);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Counts busy cycles from the next negedge and checks the walk length.
  task automatic wait_init();
    int n = 0;
    @(negedge clk);
    while (busy_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    check(n == NUM, "busy_cycles", n, NUM);
    check(upd_ready_o == 1'b1, "idle_ready", upd_ready_o, 1);
    check(tbl_re_o == 1'b0 && tbl_we_o == 1'b0, "idle_quiet", {tbl_re_o, tbl_we_o}, 0);
    @(posedge clk); #1;
  endtask

  // Holds an update until it is accepted in normal operation.
  task automatic send(input logic [G-1:0] idx, input logic taken);
    int  n = 0;
    bit  acc;
    upd_valid_i = 1'b1;
    upd_idx_i   = idx;
    upd_taken_i = taken;
    do begin
      @(negedge clk);
      acc = upd_ready_o && !busy_o;
      if (!acc) stall_cnt++;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) check(1'b0, "send_timeout", n, 200);
    upd_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || occ != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check(exp_q.size() == 0 && occ == 0, "drain", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Single update from an empty FIFO, checking exact latency.
  task automatic timed_update(input vec_t v);
    upd_valid_i = 1'b1;
    upd_idx_i   = v.idx;
    upd_taken_i = v.taken;
    @(negedge clk);
    check(upd_ready_o == 1'b1, "t_ready", upd_ready_o, 1);
    @(posedge clk); #1;
    upd_valid_i = 1'b0;
    @(negedge clk);
    check(tbl_re_o == 1'b1 && tbl_ridx_o == v.idx && tbl_we_o == 1'b0, "t_read_n1",
          {tbl_re_o, tbl_we_o, tbl_ridx_o}, {1'b1, 1'b0, v.idx});
    @(negedge clk);
    check(tbl_we_o == 1'b1 && tbl_widx_o == v.idx && tbl_re_o == 1'b0, "t_write_n2",
          {tbl_we_o, tbl_widx_o}, {1'b1, v.idx});
    check(tbl_wdata_o == v.exp, "t_wdata", tbl_wdata_o, v.exp);
    @(negedge clk);
    check(ram[v.idx] == v.exp, "t_table_n3", ram[v.idx], v.exp);
    check(tbl_we_o == 1'b0 && tbl_re_o == 1'b0, "t_quiet_n3", {tbl_we_o, tbl_re_o}, 0);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst = 1'b1; flush_i = 1'b0; upd_valid_i = 1'b0; upd_idx_i = '0; upd_taken_i = 1'b0;
    stall_cnt = 0;
    vecs[0] = '{idx: 4'd5, taken: 1'b1, exp: 2'b11};
    vecs[1] = '{idx: 4'd5, taken: 1'b1, exp: 2'b11};
    vecs[2] = '{idx: 4'd5, taken: 1'b0, exp: 2'b10};
    vecs[3] = '{idx: 4'd5, taken: 1'b0, exp: 2'b01};
    vecs[4] = '{idx: 4'd5, taken: 1'b0, exp: 2'b00};
    vecs[5] = '{idx: 4'd5, taken: 1'b0, exp: 2'b00};
    vecs[6] = '{idx: 4'd3, taken: 1'b0, exp: 2'b01};
    vecs[7] = '{idx: 4'd3, taken: 1'b1, exp: 2'b10};
    vecs[8] = '{idx: 4'd15, taken: 1'b1, exp: 2'b11};

    do_reset();
    wait_init();

    for (int i = 0; i < 9; i++) timed_update(vecs[i]);

    // Back-to-back updates overrun the 2-cycle service rate and fill the FIFO.
    stall_cnt = 0;
    for (int i = 0; i < 10; i++) send(4'(i), 1'(i % 3 != 0));
    check(stall_cnt > 0, "backpressure_seen", stall_cnt, 1);
    drain();

    // Updates offered throughout the walk are accepted and dropped.
    rst = 1'b1;
    do_reset();
    n = 0;
    while (busy_o && n < 100) begin
      upd_valid_i = busy_o;
      upd_idx_i   = 4'($urandom_range(0, NUM - 1));
      upd_taken_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    upd_valid_i = 1'b0;
    check(n == NUM, "init_len_valid_held", n, NUM);
    repeat (6) begin
      @(negedge clk);
      check(tbl_re_o == 1'b0, "no_read_after_init", tbl_re_o, 0);
    end
    @(posedge clk); #1;

    // Random traffic with an asynchronous reset in the middle.
    for (int c = 0; c < 400; c++) begin
      upd_valid_i = 1'($urandom_range(0, 2) != 0);
      upd_idx_i   = 4'($urandom_range(0, NUM - 1));
      upd_taken_i = 1'($urandom_range(0, 1));
      if (c == 150) begin
        #2 rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    upd_valid_i = 1'b0;
    drain();

`ifdef OR1K_BP_FLUSH_EN
    // Flush during a WRITE with entries queued: only the in-flight write lands.
    for (int i = 0; i < 7; i++) send(4'(i + 8), 1'b1);
    n = 0;
    while (!(tbl_we_o && !busy_o) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check(n < 50, "flush_find_write", n, 0);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    wait_init();
    repeat (8) @(posedge clk);
    #1;
    drain();
`else
    // Without the flush feature a pulse in IDLE changes nothing.
    for (int i = 0; i < 3; i++) send(4'(i + 1), 1'b0);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check(busy_o == 1'b0, "flush_ignored", busy_o, 0);
    end
    @(posedge clk); #1;
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
